// File: rtl/sap2_jk_bank_driver.sv
// Excitation driver for a negedge JK flip-flop bank with async-load inputs.
// Turns count/load requests into J/K toggle masks and Enable/Load strobes, then checks Q.
module sap2_jk_bank_driver #(
    parameter int WIDTH    = 16,
    parameter int CHECK_EN = 1
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iCount,
    input  logic             iDown,
    input  logic             iLoadReq,
    input  logic [WIDTH-1:0] iLoadData,
    input  logic             iClrErr,
    input  logic [WIDTH-1:0] iQ,
    output logic [WIDTH-1:0] oJ,
    output logic [WIDTH-1:0] oK,
    output logic             oEnable,
    output logic [WIDTH-1:0] oLoad,
    output logic             oBusy,
    output logic             oError
);
    // state    | meaning
    // IDLE     | bank holds, waiting for a request
    // COUNT    | toggle mask driven for one bank edge
    // LD_SETUP | load data presented, enable low
    // LD_PULSE | enable high for one cycle
    // LD_HOLD  | enable low, data still held
    // CHECK    | compare Q against expected; new requests accepted
    typedef enum logic [2:0] {
        IDLE, COUNT, LD_SETUP, LD_PULSE, LD_HOLD, CHECK
    } state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] expected, expectedNext;
    logic [WIDTH-1:0] jkNext, loadNext;
    logic             enableNext, busyNext, errorNext;
    logic [WIDTH-1:0] tUp, tDown;

    // Toggle masks: a bit flips when every lower bit is at its carry/borrow value
    always_comb begin
        tUp      = '0;
        tDown    = '0;
        tUp[0]   = 1'b1;
        tDown[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tUp[i]   = tUp[i-1] & iQ[i-1];
            tDown[i] = tDown[i-1] & ~iQ[i-1];
        end
    end

    always_comb begin
        stateNext    = state;
        expectedNext = expected;
        jkNext       = '0;
        loadNext     = oLoad;
        enableNext   = 1'b0;
        errorNext    = oError;

        if (iClrErr) errorNext = 1'b0;
        // A mismatch in the same cycle as a clear keeps the error set
        if (state == CHECK && iQ != expected) errorNext = 1'b1;
        if (CHECK_EN == 0) errorNext = 1'b0;

        case (state)
            IDLE, CHECK: begin
                if (iLoadReq) begin
                    stateNext    = LD_SETUP;
                    loadNext     = iLoadData;
                    expectedNext = iLoadData;
                end else if (iCount) begin
                    stateNext = COUNT;
                    if (iDown) begin
                        jkNext       = tDown;
                        expectedNext = iQ - WIDTH'(1);
                    end else begin
                        jkNext       = tUp;
                        expectedNext = iQ + WIDTH'(1);
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            COUNT:    stateNext = CHECK;
            LD_SETUP: begin
                stateNext  = LD_PULSE;
                enableNext = 1'b1;
            end
            LD_PULSE: stateNext = LD_HOLD;
            LD_HOLD:  stateNext = CHECK;
            default:  stateNext = IDLE;
        endcase

        busyNext = (stateNext == COUNT) || (stateNext == LD_SETUP) ||
                   (stateNext == LD_PULSE) || (stateNext == LD_HOLD);
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state    <= IDLE;
            expected <= '0;
            oJ       <= '0;
            oK       <= '0;
            oLoad    <= '0;
            oEnable  <= 1'b0;
            oBusy    <= 1'b0;
            oError   <= 1'b0;
        end else begin
            state    <= stateNext;
            expected <= expectedNext;
            oJ       <= jkNext;
            oK       <= jkNext;
            oLoad    <= loadNext;
            oEnable  <= enableNext;
            oBusy    <= busyNext;
            oError   <= errorNext;
        end
    end
endmodule

// File: tb/tb_sap2_jk_bank_driver.sv
// Directed bench for sap2_jk_bank_driver with a behavioural negedge JK bank model.
module tb_sap2_jk_bank_driver;
    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic        iCount = 1'b0, iDown = 1'b0, iLoadReq = 1'b0, iClrErr = 1'b0;
    logic [15:0] iLoadData = '0;
    logic [15:0] iQ, oJ, oK, oLoad;
    logic        oEnable, oBusy, oError;
    logic [15:0] bankQ;
    logic [15:0] stuck = '0;
    int          nChk = 0, nFail = 0;

    sap2_jk_bank_driver #(.WIDTH(16), .CHECK_EN(1)) dut (
        .iClk(iClk), .iReset(iReset), .iCount(iCount), .iDown(iDown),
        .iLoadReq(iLoadReq), .iLoadData(iLoadData), .iClrErr(iClrErr), .iQ(iQ),
        .oJ(oJ), .oK(oK), .oEnable(oEnable), .oLoad(oLoad), .oBusy(oBusy), .oError(oError)
    );

    always #5 iClk = ~iClk;

    // JK bank: async load wins, otherwise J=K=1 toggles
    always @(negedge iClk or negedge iReset)
        if (!iReset)      bankQ <= '0;
        else if (oEnable) bankQ <= oLoad;
        else              bankQ <= bankQ ^ (oJ & oK);

    assign iQ = bankQ & ~stuck;

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset, then count up x3
        cyc(); cyc();
        chk("rst_oJ", oJ, 0);       chk("rst_oEnable", oEnable, 0);
        chk("rst_oBusy", oBusy, 0); chk("rst_oError", oError, 0);
        chk("rst_oLoad", oLoad, 0);
        iReset = 1'b1;
        cyc();
        iCount = 1'b1; iDown = 1'b0;
        cyc(); chk("up1_oJ", oJ, 16'h0001); chk("up1_oK", oK, 16'h0001); chk("up1_busy", oBusy, 1);
        cyc(); chk("up1_chk_oJ", oJ, 0); chk("up1_chk_busy", oBusy, 0);
        cyc(); chk("up2_oJ", oJ, 16'h0003);
        cyc();
        cyc(); chk("up3_oJ", oJ, 16'h0001);
        iCount = 1'b0;
        cyc(); chk("up3_Q", iQ, 16'h0003);
        cyc(); chk("up3_err", oError, 0);

        // 2. load 0xFFFF, then count up wraps to 0
        iLoadReq = 1'b1; iLoadData = 16'hFFFF;
        cyc(); iLoadReq = 1'b0;
        chk("ld_setup_load", oLoad, 16'hFFFF); chk("ld_setup_en", oEnable, 0);
        chk("ld_setup_busy", oBusy, 1);        chk("ld_setup_oJ", oJ, 0);
        cyc(); chk("ld_pulse_en", oEnable, 1); chk("ld_pulse_load", oLoad, 16'hFFFF);
        cyc(); chk("ld_hold_en", oEnable, 0);  chk("ld_hold_load", oLoad, 16'hFFFF);
        chk("ld_hold_Q", iQ, 16'hFFFF);
        iCount = 1'b1;
        cyc(); chk("ld_chk_busy", oBusy, 0);
        cyc(); chk("wrap_up_oJ", oJ, 16'hFFFF); chk("wrap_up_oK", oK, 16'hFFFF);
        iCount = 1'b0;
        cyc(); chk("wrap_up_Q", iQ, 16'h0000);
        cyc(); chk("wrap_up_err", oError, 0);

        // 3. count down from 0 twice
        iCount = 1'b1; iDown = 1'b1;
        cyc(); chk("dn1_oJ", oJ, 16'hFFFF);
        cyc(); chk("dn1_Q", iQ, 16'hFFFF);
        cyc(); chk("dn2_oJ", oJ, 16'h0001);
        iCount = 1'b0; iDown = 1'b0;
        cyc(); chk("dn2_Q", iQ, 16'hFFFE);
        cyc(); chk("dn2_err", oError, 0);

        // 4. simultaneous load and count: load wins, busy-time counts ignored
        iLoadReq = 1'b1; iCount = 1'b1; iLoadData = 16'h1234;
        cyc(); iLoadReq = 1'b0;
        chk("lc_setup_oJ", oJ, 0);
        cyc(); chk("lc_pulse_oJ", oJ, 0); chk("lc_pulse_en", oEnable, 1);
        cyc(); chk("lc_hold_oJ", oJ, 0);
        cyc(); iCount = 1'b0;
        chk("lc_check_oJ", oJ, 0); chk("lc_Q", iQ, 16'h1234); chk("lc_busy", oBusy, 0);
        cyc(); chk("lc_idle_oJ", oJ, 0); chk("lc_Q2", iQ, 16'h1234); chk("lc_err", oError, 0);

        // 5. bit 3 stuck at 0: 7 -> 8 mismatches
        iLoadReq = 1'b1; iLoadData = 16'h0007;
        cyc(); iLoadReq = 1'b0;
        cyc(); cyc(); stuck = 16'h0008;
        iCount = 1'b1;
        cyc(); chk("stk_chk_err", oError, 0);
        cyc(); iCount = 1'b0; chk("stk_oJ", oJ, 16'h000F);
        cyc(); chk("stk_Q", iQ, 16'h0000);
        cyc(); chk("stk_err_set", oError, 1);
        cyc(); cyc(); chk("stk_err_sticky", oError, 1);
        iClrErr = 1'b1;
        cyc(); iClrErr = 1'b0;
        chk("stk_err_clr", oError, 0);
        stuck = '0;

        // 6. reset during LD_PULSE
        iLoadReq = 1'b1; iLoadData = 16'hABCD;
        cyc(); iLoadReq = 1'b0;
        cyc(); chk("ab_pulse_en", oEnable, 1);
        #2 iReset = 1'b0;
        #1 chk("ab_en", oEnable, 0); chk("ab_busy", oBusy, 0);
        cyc(); iReset = 1'b1;
        cyc(); chk("ab_post_busy", oBusy, 0); chk("ab_post_err", oError, 0);
        chk("ab_post_oJ", oJ, 0); chk("ab_post_en", oEnable, 0);

        $display("%0d/%0d checks passed", nChk - nFail, nChk);
        $finish;
    end
endmodule
